// File: rtl/mux_nt1_reg.sv
// N-to-1 channel mux with registered output; select from explicit load or an auto-scanner.
// Latency: one clock from din/cur_sel to dout; a load takes effect on cur_sel at the load edge.
// No backpressure: en gates the output register and scanner, holding state while low.
module mux_nt1_reg #(
   parameter int WIDTH    = 8,
   parameter int NUM_CH   = 4,
   parameter int SEL_W    = 2,
   parameter int SCAN_DIV = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH*NUM_CH-1:0]   din,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic                      sel_load,
   input  logic                      mode,
   input  logic                      en,
   output logic [WIDTH-1:0]          dout,
   output logic                      dout_valid,
   output logic [SEL_W-1:0]          cur_sel,
   output logic                      wrap,
   output logic                      sel_err
);

   // Divider needs at least one bit even when every enabled clock advances.
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

   logic [WIDTH-1:0] ch [NUM_CH];

   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             wrap_q, wrap_d;
   logic             sel_err_q, sel_err_d;
   logic             load_ok;

   // Unpack the flat channel bus into an indexable array.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch[i] = din[i*WIDTH +: WIDTH];
      end
   end

   assign load_ok = sel_load && (sel_in <= LAST_CH);

   // Next-state: output capture, select load (highest priority), then scanning.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      cur_sel_d    = cur_sel_q;
      div_d        = div_q;
      wrap_d       = 1'b0;
      sel_err_d    = 1'b0;

      if (en) begin
         dout_d       = ch[cur_sel_q];
         dout_valid_d = 1'b1;
      end

      // An out-of-range load is flagged and otherwise ignored, so the scanner keeps running.
      if (sel_load && !load_ok) begin
         sel_err_d = 1'b1;
      end

      if (load_ok) begin
         cur_sel_d = sel_in;
         div_d     = '0;
      end else if (!mode) begin
         div_d = '0;
      end else if (en) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            if (cur_sel_q == LAST_CH) begin
               cur_sel_d = '0;
               wrap_d    = 1'b1;
            end else begin
               cur_sel_d = cur_sel_q + 1'b1;
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   // State registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         cur_sel_q    <= '0;
         div_q        <= '0;
         wrap_q       <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         cur_sel_q    <= cur_sel_d;
         div_q        <= div_d;
         wrap_q       <= wrap_d;
         sel_err_q    <= sel_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign cur_sel    = cur_sel_q;
   assign wrap       = wrap_q;
   assign sel_err    = sel_err_q;

endmodule

// File: doc/mux_nt1_reg.md
Name: mux_nt1_reg

Overview:
Parametrised N-to-1 multiplexer with a registered output, for WIDTH-bit data channels. The select is held in an internal register. It is set either by an explicit load (manual mode) or by a built-in scanner that steps through channels every SCAN_DIV enabled clocks (auto mode). It is used in datapath exercises for operand/source selection and for time-multiplexed display or monitor sampling.

Parameters:
WIDTH, 8, data width of each channel and of dout
NUM_CH, 4, number of input channels (>=2)
SEL_W, 2, select width; must equal ceil(log2(NUM_CH))
SCAN_DIV, 4, enabled clocks spent on each channel in auto mode (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
din  in  WIDTH*NUM_CH  packed channels; channel i = din[i*WIDTH +: WIDTH]
sel_in  in  SEL_W  select value to load
sel_load  in  1  load strobe for sel_in, one cycle
mode  in  1  0 = manual, 1 = auto-scan
en  in  1  clock enable for output register and scanner
dout  out  WIDTH  registered selected channel
dout_valid  out  1  dout was updated at the last edge
cur_sel  out  SEL_W  current select register
wrap  out  1  one-cycle pulse when the scan steps NUM_CH-1 -> 0
sel_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, no clock needed): dout=0, dout_valid=0, cur_sel=0, wrap=0, sel_err=0, scan divider=0. Reset asserted mid-operation clears all state immediately. First update occurs on the first rising edge after release.
- Output path:
  - en=1: dout <= din[cur_sel] and dout_valid <= 1. Uses the pre-edge cur_sel. Latency is one cycle from din to dout. A newly loaded select appears in dout one edge after cur_sel changes.
  - en=0: dout holds and dout_valid <= 0.
- Load (either mode, independent of en):
  - sel_load=1 with sel_in < NUM_CH: cur_sel <= sel_in and divider <= 0.
  - sel_load=1 with sel_in >= NUM_CH: cur_sel unchanged, sel_err <= 1 for one cycle.
- Manual mode (mode=0): cur_sel changes only by load. Divider is held at 0, wrap stays 0.
- Auto mode (mode=1, en=1, no load):
  - divider == SCAN_DIV-1: divider <= 0 and cur_sel <= cur_sel+1, or 0 if cur_sel == NUM_CH-1. On that wrap, wrap <= 1 for one cycle.
  - otherwise: divider <= divider+1.
- SCAN_DIV=1: advance on every enabled cycle.
- Auto mode with en=0: divider and cur_sel frozen, wrap=0.
- Simultaneous load and scan advance: the load wins. Divider goes to 0, no advance, no wrap pulse.
- Mode change 1 -> 0: scan stops, cur_sel retained. Mode change 0 -> 1: scanning starts from divider=0 on the current cur_sel.
- wrap and sel_err are registered pulses, 0 in every other cycle.

Test Plan:
(WIDTH=8, NUM_CH=4, SCAN_DIV=4; din channels 0..3 = 8'h11, 8'h22, 8'h33, 8'h44 unless noted.)
1. Reset and first capture: rst_n=0 -> all outputs 0. Release with en=1, mode=0 -> after first edge dout=8'h11 and dout_valid=1.
2. Manual load: sel_in=2 with sel_load pulsed one cycle -> cur_sel=2 at that edge, dout=8'h33 at the next edge. Change din ch2 to 8'h5A -> dout=8'h5A one cycle later.
3. Invalid select (NUM_CH=3, SEL_W=2, cur_sel=1): sel_in=3 with sel_load -> cur_sel stays 1, sel_err=1 for exactly one cycle.
4. Auto scan from cur_sel=0 with mode=1, en=1 for 20 cycles:
   - cur_sel holds 0 for 4 edges, then steps 1, 2, 3, 0 every 4 edges.
   - wrap=1 only in the cycle after the 3 -> 0 step.
   - dout shows 11,11,11,11,22,... lagging cur_sel by one cycle.
5. Freeze and priority:
   - Drop en for 3 cycles mid-channel -> cur_sel and dout hold, dout_valid=0. Re-enable -> the remaining count resumes with no lost step.
   - Assert sel_load sel_in=1 on an advance cycle -> cur_sel=1, divider restarts, no wrap.
6. Async reset mid-scan: pull rst_n low between edges at cur_sel=3 -> dout, cur_sel and dout_valid go to 0 before the next edge. After release, scanning restarts at channel 0.
